// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB-75 line scanner and its BCM timer.
package hub75_pkg;

  typedef enum logic [2:0] {
    kPrime,
    kWaitGen,
    kShift,
    kLatch,
    kBlank,
    kDisplay
  } state_t;

  localparam int kPanelWidth = 64;
  localparam int kPlaneCount = 8;
  localparam int kRowCount   = 32;

  localparam int kAddrW  = 7;
  localparam int kDataW  = 48;
  localparam int kTimerW = 24;

  // Byte offsets of {R,G,B} for the upper and lower half pixels in read_data.
  localparam int kUpperR = 40;
  localparam int kUpperG = 32;
  localparam int kUpperB = 24;
  localparam int kLowerR = 16;
  localparam int kLowerG = 8;
  localparam int kLowerB = 0;

endpackage

// File: rtl/bcm_timer.sv
// Down-counter for one BCM plane's on-time; reloads while load is high, done at zero.
module bcm_timer
  import hub75_pkg::*;
#(
  parameter int WIDTH = kTimerW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - WIDTH'(1);
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hub75_line_scanner.sv
// Reads rows back from the double-buffered line buffer and drives a HUB-75 panel with
// 8-plane BCM. Define HUB75_GHOST_BLANK_EN to insert OE-off blanking after each latch.
module hub75_line_scanner
  import hub75_pkg::*;
#(
  parameter int display_base = 128,
  parameter int blank_cycles = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [4:0]        gen_y,
  output logic [9:0]        frame_count,
  output logic              gen_start,
  input  logic              gen_is_idle,
  output logic [kAddrW-1:0] read_address,
  input  logic [kDataW-1:0] read_data,
  output logic [5:0]        panel_rgb,
  output logic              panel_clock,
  output logic              panel_latch,
  output logic              panel_oe_n,
  output logic [4:0]        panel_address
);

  localparam logic [7:0]  kShiftEnd  = 8'(2 * kPanelWidth);
  localparam logic [15:0] kBlankEnd  = 16'(blank_cycles - 1);
  localparam logic [2:0]  kLastPlane = 3'(kPlaneCount - 1);

  state_t      state, next_state;
  logic [7:0]  sc;
  logic [2:0]  b;
  logic [4:0]  row;
  logic        prime_step;
  logic [1:0]  wait_cnt;
  logic [15:0] blank_cnt;
  logic        pulse, advance_row, can_start, timer_done;
  logic [4:0]  next_gen_y;
  logic [7:0]  r1, g1, b1, r2, g2, b2;

  // Idle seen in the pulse cycle or the one after belongs to the previous request.
  assign can_start = gen_is_idle && (wait_cnt == 2'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= kPrime;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pulse       = 1'b0;
    advance_row = 1'b0;
    next_gen_y  = gen_y;
    case (state)
      kPrime: begin
        if (can_start) begin
          pulse = 1'b1;
          if (prime_step) begin
            next_gen_y = 5'd1;
            next_state = kShift;
          end
        end
      end
      kShift:   if (sc == kShiftEnd) next_state = kLatch;
      kLatch: begin
`ifdef HUB75_GHOST_BLANK_EN
        next_state = (blank_cycles > 0) ? kBlank : kDisplay;
`else
        next_state = kDisplay;
`endif
      end
      kBlank:   if (blank_cnt >= kBlankEnd) next_state = kDisplay;
      kDisplay: begin
        if (timer_done) begin
          if (b != kLastPlane) begin
            next_state = kShift;
          end else if (can_start) begin
            advance_row = 1'b1;
            next_state  = kShift;
          end else begin
            next_state = kWaitGen;
          end
        end
      end
      kWaitGen: begin
        if (can_start) begin
          advance_row = 1'b1;
          next_state  = kShift;
        end
      end
      default:  next_state = kPrime;
    endcase
    // The generator always works one row ahead of the displayed row.
    if (advance_row) begin
      pulse      = 1'b1;
      next_gen_y = row + 5'd2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sc            <= '0;
      b             <= '0;
      row           <= '0;
      prime_step    <= 1'b0;
      wait_cnt      <= '0;
      blank_cnt     <= '0;
      gen_start     <= 1'b0;
      gen_y         <= '0;
      frame_count   <= '0;
      panel_address <= '0;
    end else begin
      gen_start <= pulse;
      if (pulse) begin
        gen_y    <= next_gen_y;
        wait_cnt <= 2'd2;
        if (advance_row && next_gen_y == 5'd0) frame_count <= frame_count + 10'd1;
      end else if (wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (state == kPrime && pulse) prime_step <= 1'b1;
      if (advance_row) row <= row + 5'd1;
      sc        <= (state == kShift && sc != kShiftEnd) ? sc + 8'd1 : 8'd0;
      blank_cnt <= (state == kBlank) ? blank_cnt + 16'd1 : 16'd0;
      if (state == kShift && sc == kShiftEnd) panel_address <= row;
      if (state == kDisplay && timer_done) b <= b + 3'd1;
    end
  end

  bcm_timer #(.WIDTH(kTimerW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (state != kDisplay),
    .load_value (kTimerW'(display_base) << b),
    .done       (timer_done)
  );

  // sc=0 is the prefetch; pixel x occupies sc=2x+1 (clock low) and sc=2x+2 (clock high).
  assign read_address = (state == kShift) ? {row[0], sc[6:1]} : '0;

  assign r1 = read_data[kUpperR +: 8];
  assign g1 = read_data[kUpperG +: 8];
  assign b1 = read_data[kUpperB +: 8];
  assign r2 = read_data[kLowerR +: 8];
  assign g2 = read_data[kLowerG +: 8];
  assign b2 = read_data[kLowerB +: 8];

  assign panel_rgb   = (state == kShift && sc != 8'd0) ?
                       {r1[b], g1[b], b1[b], r2[b], g2[b], b2[b]} : 6'd0;
  assign panel_clock = (state == kShift) && (sc != 8'd0) && !sc[0];
  assign panel_latch = (state == kLatch);
  assign panel_oe_n  = (state != kDisplay);

endmodule

// File: tb/tb_hub75_line_scanner.sv
// Directed/randomized bench for hub75_line_scanner with a line-buffer and generator model.
module tb_hub75_line_scanner;

  localparam int DISPLAY_BASE = 2;
  localparam int BLANK = 4;
`ifdef HUB75_GHOST_BLANK_EN
  localparam int EXP_GAP = BLANK;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  gen_y;
  logic [9:0]  frame_count;
  logic        gen_start;
  logic        gen_is_idle;
  logic [6:0]  read_address;
  logic [47:0] read_data = '0;
  logic [5:0]  panel_rgb;
  logic        panel_clock;
  logic        panel_latch;
  logic        panel_oe_n;
  logic [4:0]  panel_address;

  hub75_line_scanner #(.display_base(DISPLAY_BASE), .blank_cycles(BLANK)) dut (
    .clock         (clock),
    .reset         (reset),
    .gen_y         (gen_y),
    .frame_count   (frame_count),
    .gen_start     (gen_start),
    .gen_is_idle   (gen_is_idle),
    .read_address  (read_address),
    .read_data     (read_data),
    .panel_rgb     (panel_rgb),
    .panel_clock   (panel_clock),
    .panel_latch   (panel_latch),
    .panel_oe_n    (panel_oe_n),
    .panel_address (panel_address)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // Line buffer: registered read, one cycle latency.
  logic [47:0] mem [128];
  always @(posedge clock) read_data <= mem[read_address];

  // Generator: busy for a fixed or random time after each request, or held busy.
  int busy = 0;
  bit gen_hold = 1'b0;
  bit rand_busy = 1'b0;
  always @(posedge clock) begin
    if (reset) busy <= 0;
    else if (gen_start) busy <= rand_busy ? int'($urandom_range(1700, 5)) : 10;
    else if (busy != 0) busy <= busy - 1;
  end
  assign gen_is_idle = (busy == 0) && !gen_hold;

  typedef struct {
    int rises; int latch_len; int addr; logic [383:0] rgb; int gap; int run; int cycle;
  } plane_t;
  typedef struct { int gen_y; int frame; int cycle; } pulse_t;

  plane_t planes[$];
  pulse_t pulses[$];
  int rises, run_len, gap_cnt, first_rise;
  int stray = 0, bad_pulse = 0, oe_low_total = 0;
  bit in_run, after_latch, prev_clk, prev_latch, prev_start;
  logic [383:0] cur;
  plane_t rec;
  pulse_t pr;

  // Panel-side observer, sampling on the falling edge.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      planes.delete(); pulses.delete();
      rises = 0; cur = '0; run_len = 0; gap_cnt = 0; first_rise = -1;
      in_run = 0; after_latch = 0; prev_clk = 0; prev_latch = 0; prev_start = 0;
    end else begin
      if (panel_clock && !prev_clk) begin
        if (first_rise < 0) first_rise = cycle;
        if (rises < 64) cur[6*rises +: 6] = panel_rgb;
        rises++;
      end
      if (panel_latch) begin
        if (!prev_latch) begin
          rec.rises = rises; rec.latch_len = 1; rec.addr = int'(panel_address);
          rec.rgb = cur; rec.gap = -1; rec.run = 0; rec.cycle = cycle;
          planes.push_back(rec);
          rises = 0; cur = '0; after_latch = 1; gap_cnt = 0;
        end else begin
          planes[planes.size()-1].latch_len++;
        end
      end
      if (!panel_oe_n) begin
        if (!in_run) begin
          in_run = 1; run_len = 0;
          if (!after_latch || planes.size() == 0) stray++;
          else planes[planes.size()-1].gap = gap_cnt;
          after_latch = 0;
        end
        run_len++; oe_low_total++;
      end else begin
        if (in_run) begin
          in_run = 0;
          if (planes.size() > 0) planes[planes.size()-1].run = run_len;
        end
        if (after_latch && !panel_latch) gap_cnt++;
      end
      if (gen_start) begin
        if (prev_start || !gen_is_idle) bad_pulse++;
        pr.gen_y = int'(gen_y); pr.frame = int'(frame_count); pr.cycle = cycle;
        pulses.push_back(pr);
      end
      prev_clk = panel_clock; prev_latch = panel_latch; prev_start = gen_start;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_wide(input string tag, input logic [383:0] observed, input logic [383:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected shifted bits of a row: bit `plane` of each colour byte, pixel by pixel.
  function automatic logic [383:0] exp_rgb(input int bank, input int plane);
    logic [383:0] r;
    logic [47:0] d;
    r = '0;
    for (int x = 0; x < 64; x++) begin
      d = mem[bank*64 + x];
      r[6*x +: 6] = {d[40+plane], d[32+plane], d[24+plane], d[16+plane], d[8+plane], d[plane]};
    end
    return r;
  endfunction

  task automatic check_planes(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      int row = (k / 8) % 32;
      int pl  = k % 8;
      check($sformatf("rises k%0d", k), planes[k].rises, 64);
      check($sformatf("latch_len k%0d", k), planes[k].latch_len, 1);
      check($sformatf("panel_address k%0d", k), planes[k].addr, row);
      check($sformatf("blank_gap k%0d", k), planes[k].gap, EXP_GAP);
      check($sformatf("oe_run k%0d", k), planes[k].run, DISPLAY_BASE << pl);
      check_wide($sformatf("rgb k%0d", k), planes[k].rgb, exp_rgb(row % 2, pl));
    end
  endtask

  task automatic check_quiet_outputs(input string t);
    check({t, " oe_n"}, panel_oe_n, 1);
    check({t, " panel_clock"}, panel_clock, 0);
    check({t, " panel_latch"}, panel_latch, 0);
    check({t, " panel_rgb"}, panel_rgb, 0);
    check({t, " panel_address"}, panel_address, 0);
    check({t, " gen_start"}, gen_start, 0);
    check({t, " gen_y"}, gen_y, 0);
    check({t, " frame_count"}, frame_count, 0);
    check({t, " read_address"}, read_address, 0);
  endtask

  initial begin
    int n;
    int oe_snap, pulse_snap;
    logic [383:0] v;
    for (int i = 0; i < 128; i++) mem[i] = {16'($urandom), $urandom};
    mem[5] = 48'hFF0000_0000FF;
    mem[6] = 48'h800000_000000;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 check_quiet_outputs("reset");
    @(negedge clock) reset = 1'b0;

    n = 0;
    while (pulses.size() < 2 && n < 200) begin @(negedge clock); n++; end
    check("prime pulses seen", pulses.size() >= 2, 1);
    check("prime pulse0 gen_y", pulses[0].gen_y, 0);
    check("prime pulse0 frame", pulses[0].frame, 0);
    check("prime pulse1 gen_y", pulses[1].gen_y, 1);
    check("prime pulse spacing", pulses[1].cycle - pulses[0].cycle, 12);
    gen_hold = 1'b1;
    rand_busy = 1'b1;
    n = 0;
    while (first_rise < 0 && n < 50) begin @(negedge clock); n++; end
    check("first rise after pulse1", first_rise - pulses[1].cycle, 2);

    // Row 0 finishes, then the generator stays busy.
    n = 0;
    while (!(planes.size() >= 8 && !in_run && planes[7].run != 0) && n < 3000) begin
      @(negedge clock); n++;
    end
    check("row0 done", planes.size() >= 8 && planes[7].run != 0, 1);
    oe_snap = oe_low_total;
    pulse_snap = pulses.size();
    repeat (5000) @(negedge clock);
    check("stall oe low cycles", oe_low_total - oe_snap, 0);
    check("stall pulses", pulses.size() - pulse_snap, 0);
    gen_hold = 1'b0;
    n = 0;
    while (pulses.size() < 3 && n < 10) begin @(negedge clock); n++; end
    check("post-stall pulse seen", pulses.size() >= 3, 1);
    check("post-stall gen_y", pulses[2].gen_y, 2);

    for (int pl = 0; pl < 8; pl++) begin
      v = planes[pl].rgb;
      check($sformatf("pixel5 plane%0d", pl), v[30 +: 6], 6'b100001);
      check($sformatf("pixel6 plane%0d", pl), v[36 +: 6], (pl == 7) ? 6'b100000 : 6'b000000);
    end

    // A full frame plus the first row of the next one.
    n = 0;
    while (planes.size() < 265 && n < 75000) begin @(negedge clock); n++; end
    check("frame planes seen", planes.size() >= 265, 1);
    check_planes(0, 264);
    for (int k = 0; k < 34; k++) begin
      check($sformatf("pulse%0d gen_y", k), pulses[k].gen_y, k % 32);
      check($sformatf("pulse%0d frame", k), pulses[k].frame, k / 32);
    end
    check("address before wrap", planes[31*8].addr, 31);
    check("address after wrap", planes[32*8].addr, 0);
    check("stray oe runs", stray, 0);
    check("bad gen_start", bad_pulse, 0);

    // Reset partway through plane 4's display.
    n = 0;
    while (!(planes.size() >= 269 && in_run && run_len >= 10) && n < 3000) begin
      @(negedge clock); n++;
    end
    check("reached plane4 display", planes.size() >= 269 && in_run, 1);
    reset = 1'b1;
    @(posedge clock);
    #1 check_quiet_outputs("mid reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (pulses.size() < 1 && n < 50) begin @(negedge clock); n++; end
    check("reprime pulse seen", pulses.size() >= 1, 1);
    check("reprime gen_y", pulses[0].gen_y, 0);
    check("reprime frame", pulses[0].frame, 0);
    n = 0;
    while (planes.size() < 9 && n < 6000) begin @(negedge clock); n++; end
    check("reprime row0 seen", planes.size() >= 9, 1);
    check_planes(0, 8);
    check("final stray oe runs", stray, 0);
    check("final bad gen_start", bad_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
